mat3_mem_sequencer: RTL and testbench
=====================================

# mat3_mem_sequencer

Access sequencer that drives the single-port 18-bit matrix memory (32 words, combinational read, posedge write) from the datapath side. On command it either loads a 3x3 matrix, nine elements streamed in over a valid/ready handshake, into consecutive memory words, or dumps nine consecutive words out as a valid/ready stream. It sits between the matrix memories and the host/stream interface of the matmul datapath.

## Interface
- DATA_W, 18, element width
- ADDR_W, 5, memory address width
- N_ELEM, 9, elements per transfer
- BASE_ADDR, 0, first word address; BASE_ADDR+N_ELEM-1 must be <= 8 (memory returns 0 above word 8)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_start  in  1  start a transfer; sampled only in IDLE
- cmd_write  in  1  1 = load (stream->memory), 0 = dump (memory->stream); sampled with cmd_start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at transfer completion
- s_data  in  DATA_W  load stream data
- s_valid  in  1  load stream valid
- s_ready  out  1  high only in LOAD
- m_data  out  DATA_W  dump stream data (registered)
- m_valid  out  1  dump stream valid (registered)
- m_ready  in  1  dump stream ready
- mem_addr  out  ADDR_W  BASE_ADDR + idx
- mem_wdata  out  DATA_W  equals s_data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr/mem_re

## Operation
- States: IDLE, LOAD, DUMP, DONE. Element counter idx, width clog2(N_ELEM+1), cleared on entry to LOAD/DUMP.
- IDLE: on cmd_start go to LOAD if cmd_write=1, else DUMP. cmd_start in any other state is ignored.
- LOAD: s_ready=1. mem_we = s_valid (combinational), mem_wdata = s_data, mem_addr = BASE_ADDR+idx. Each accepted beat increments idx. The beat with idx=N_ELEM-1 moves the block to DONE. Gaps in s_valid stall without side effects.
- DUMP: mem_re=1, mem_addr = BASE_ADDR+idx. When idx<N_ELEM and (!m_valid || m_ready): m_data <= mem_rdata, m_valid <= 1, idx++. When m_valid && m_ready and no new load: m_valid <= 0. Once idx==N_ELEM and the last beat is accepted, go to DONE. m_data stays stable while m_valid && !m_ready.
- DONE: done=1 for one cycle, then IDLE.
- mem_we=0 and mem_re=0 outside LOAD/DUMP. Writes occur only on accepted beats.
- Address arithmetic is ADDR_W bits with no wrap. Parameter legality is checked by an elaboration-time assertion.

## Timing
- Reset values: state=IDLE, idx=0, busy=0, done=0, s_ready=0, m_valid=0, m_data=0, mem_we=0, mem_re=0, mem_addr=BASE_ADDR.
- Start: cmd_start sampled at edge T puts the block in LOAD/DUMP and raises busy from T+1.
- Load: memory word written at the same edge the beat is accepted. With continuous s_valid, nine beats take cycles T+1..T+9. done is high in T+10 and busy drops at T+11.
- Dump: first m_valid in T+2. With m_ready held high, one beat per cycle over T+2..T+10. done is high in T+11.
- Back-pressure: full throughput is retained. A beat transfers on every cycle with m_valid && m_ready. No bubble is inserted after a stall.
- Reset mid-transfer: returns immediately to reset values. Memory words already written stay written. The next command restarts at idx=0.
- A cmd_start in the same cycle as done is ignored. It is accepted again from the IDLE cycle.

## Structure
- Shared package mat_pkg: state enum (IDLE/LOAD/DUMP/DONE), DATA_W=18, ADDR_W=5, N_ELEM=9 constants used by all matrix blocks.
- Single module, no sub-modules. The dump output register is inline, not a separate skid buffer.

## Test plan
- Load 1..9 with s_valid held high, BASE_ADDR=0 -> writes to addr 0..8 on consecutive edges. done pulses once. A memory model read back gives 1..9.
- Dump after that load with m_ready=1 -> m_data 1..9 on cycles T+2..T+10, done at T+11, exactly nine m_valid beats.
- Dump with m_ready toggling 1,0,0,1,... -> sequence 1..9 with no loss or duplication, and m_data stable during every stall.
- Load with s_valid gaps (beat every third cycle) -> nine writes, no write on gap cycles, addresses still 0..8.
- Assert rst after the 4th dump beat -> all outputs return to reset values asynchronously. A new dump then yields 1..9 from addr 0.
- cmd_start pulses while busy, including the DONE cycle -> ignored, with no extra memory activity and no second done.

Source files
------------

// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared constants and state encoding for the matrix blocks
package mat_pkg;

    localparam int MAT_DATA_W = 18;
    localparam int MAT_ADDR_W = 5;
    localparam int MAT_N_ELEM = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mat3_mem_sequencer.sv
// rtl/mat3_mem_sequencer.sv - loads or dumps one 3x3 matrix between a stream and the matrix memory
module mat3_mem_sequencer
    import mat_pkg::*;
#(
    parameter int DATA_W    = MAT_DATA_W,
    parameter int ADDR_W    = MAT_ADDR_W,
    parameter int N_ELEM    = MAT_N_ELEM,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic              cmd_write,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int IDX_W = $clog2(N_ELEM + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(N_ELEM - 1);
    localparam logic [IDX_W-1:0]  FULL = IDX_W'(N_ELEM);

    // The memory only holds meaningful data in words 0..8.
    if (BASE_ADDR < 0 || BASE_ADDR + N_ELEM - 1 > 8 || BASE_ADDR + N_ELEM > (1 << ADDR_W)) begin : g_param_check
        $error("mat3_mem_sequencer: BASE_ADDR + N_ELEM - 1 must lie within words 0..8");
    end

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0] m_data_nxt;
    logic              m_valid_nxt;
    logic [ADDR_W-1:0] cur_addr;

    assign cur_addr  = BASE + ADDR_W'(idx);
    assign busy      = (state != ST_IDLE);
    assign mem_wdata = s_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            m_data  <= m_data_nxt;
            m_valid <= m_valid_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        m_data_nxt  = m_data;
        m_valid_nxt = m_valid;
        s_ready     = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = BASE;
        done        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_start) begin
                    idx_nxt   = '0;
                    state_nxt = cmd_write ? ST_LOAD : ST_DUMP;
                end
            end
            ST_LOAD: begin
                s_ready  = 1'b1;
                mem_we   = s_valid;
                mem_addr = cur_addr;
                if (s_valid) begin
                    idx_nxt = idx + 1'b1;
                    if (idx == LAST) state_nxt = ST_DONE;
                end
            end
            ST_DUMP: begin
                mem_re   = 1'b1;
                mem_addr = cur_addr;
                if (m_valid && m_ready) m_valid_nxt = 1'b0;
                // Refill in the same cycle the held beat leaves, so no bubble follows a stall.
                if (idx < FULL && (!m_valid || m_ready)) begin
                    m_data_nxt  = mem_rdata;
                    m_valid_nxt = 1'b1;
                    idx_nxt     = idx + 1'b1;
                end
                if (idx == FULL && m_valid && m_ready) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mat3_mem_sequencer.sv
// tb/tb_mat3_mem_sequencer.sv - directed self-checking bench for mat3_mem_sequencer
module tb_mat3_mem_sequencer;

    localparam int DW = 18;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_start, cmd_write, busy, done;
    logic [DW-1:0] s_data, m_data, mem_wdata, mem_rdata;
    logic          s_valid, s_ready, m_valid, m_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mat3_mem_sequencer dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_write(cmd_write),
        .busy(busy), .done(done), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    // Behavioural matrix memory: combinational read, zero above word 8.
    logic [DW-1:0] mem [0:31];
    assign mem_rdata = (mem_re && mem_addr <= 5'd8) ? mem[mem_addr] : '0;
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct {
        logic          cs, cw, sv;
        logic [DW-1:0] sd;
        logic          e_busy, e_done, e_sready, e_we;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " s_ready"}, s_ready, 0);
        check({tag, " m_valid"}, m_valid, 0);
        check({tag, " m_data"}, m_data, 0);
        check({tag, " mem_we"}, mem_we, 0);
        check({tag, " mem_re"}, mem_re, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
    endtask

    // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0,1 repeating.
    task automatic run_dump(input string tag, input int mode, input bit spam, input int rst_beat,
                            input logic [DW-1:0] base);
        int c, nbeats, ndone, nwe;
        logic [DW-1:0] held;
        bit holding;
        @(negedge clk);
        cmd_start = 1'b1; cmd_write = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
        nbeats = 0; ndone = 0; nwe = 0; holding = 1'b0; held = '0;
        for (c = 1; c <= 60; c++) begin
            @(negedge clk);
            cmd_start = spam && (c <= 11);
            cmd_write = spam;
            m_ready   = (mode == 0) ? 1'b1 : (((c - 1) % 4 == 0) || ((c - 1) % 4 == 3));
            #1;
            if (mem_we) nwe++;
            if (holding && m_valid) check($sformatf("%s stall c%0d", tag, c), m_data, held);
            if (m_valid && m_ready) begin
                check($sformatf("%s beat%0d data", tag, nbeats), m_data, base + DW'(nbeats));
                if (mode == 0) check($sformatf("%s beat%0d cycle", tag, nbeats), c, nbeats + 2);
                nbeats++;
                holding = 1'b0;
            end else if (m_valid) begin
                held = m_data;
                holding = 1'b1;
            end
            if (done) begin
                ndone++;
                if (mode == 0) check({tag, " done cycle"}, c, 11);
            end
            if (rst_beat != 0 && nbeats == rst_beat) begin
                #2 rst = 1'b1;
                #1 check_reset_outputs({tag, " async rst"});
                @(negedge clk);
                rst = 1'b0; m_ready = 1'b0;
                return;
            end
            if (ndone > 0 && !busy) break;
        end
        cmd_start = 1'b0;
        check({tag, " beats"}, nbeats, 9);
        check({tag, " done pulses"}, ndone, 1);
        check({tag, " writes"}, nwe, 0);
        if (mode == 0) check({tag, " idle cycle"}, c, 12);
    endtask

    // One beat every third cycle.
    task automatic run_gap_load(input logic [DW-1:0] base);
        int c, nb, done_c;
        @(negedge clk);
        cmd_start = 1'b1; cmd_write = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        nb = 0; done_c = -1;
        for (c = 1; c <= 60; c++) begin
            @(negedge clk);
            cmd_start = 1'b0;
            s_valid = (nb < 9) && ((c - 1) % 3 == 0);
            s_data  = base + DW'(nb);
            #1;
            check($sformatf("gap c%0d we", c), mem_we, s_valid);
            if (s_valid) begin
                check($sformatf("gap beat%0d addr", nb), mem_addr, nb);
                check($sformatf("gap beat%0d ready", nb), s_ready, 1);
                nb++;
            end
            if (done) done_c = c;
            if (done_c > 0 && !busy) break;
        end
        s_valid = 1'b0;
        check("gap done cycle", done_c, 26);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rst = 1'b1; cmd_start = 1'b0; cmd_write = 1'b0;
        s_data = '0; s_valid = 1'b0; m_ready = 1'b0;

        tbl[0] = '{cs:1, cw:1, sv:0, sd:0, e_busy:0, e_done:0, e_sready:0, e_we:0, e_addr:0};
        for (int i = 1; i <= 9; i++)
            tbl[i] = '{cs:(i == 5), cw:0, sv:1, sd:DW'(i), e_busy:1, e_done:0, e_sready:1,
                       e_we:1, e_addr:AW'(i - 1)};
        tbl[10] = '{cs:1, cw:1, sv:0, sd:0, e_busy:1, e_done:1, e_sready:0, e_we:0, e_addr:0};
        tbl[11] = '{cs:0, cw:0, sv:0, sd:0, e_busy:0, e_done:0, e_sready:0, e_we:0, e_addr:0};

        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cmd_start = tbl[i].cs; cmd_write = tbl[i].cw;
            s_valid = tbl[i].sv; s_data = tbl[i].sd;
            #1;
            check($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
            check($sformatf("vec%0d done", i), done, tbl[i].e_done);
            check($sformatf("vec%0d s_ready", i), s_ready, tbl[i].e_sready);
            check($sformatf("vec%0d mem_we", i), mem_we, tbl[i].e_we);
            if (tbl[i].e_we) check($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].e_addr);
        end
        cmd_start = 1'b0; s_valid = 1'b0;

        for (int k = 0; k <= 9; k++)
            check($sformatf("mem[%0d]", k), mem[k], (k < 9) ? k + 1 : 0);

        run_dump("dump_full", 0, 1'b0, 0, 18'd1);
        run_dump("dump_toggle", 1, 1'b0, 0, 18'd1);
        run_dump("dump_spam", 0, 1'b1, 0, 18'd1);
        run_dump("dump_rst", 0, 1'b0, 4, 18'd1);
        run_dump("dump_after_rst", 0, 1'b0, 0, 18'd1);

        run_gap_load(18'd101);
        for (int k = 0; k < 9; k++)
            check($sformatf("gap mem[%0d]", k), mem[k], 101 + k);
        run_dump("dump_gap", 0, 1'b0, 0, 18'd101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
